// File: rtl/bcd_sseg_scan4_if.sv
// Display-side bundle of the 4-digit BCD seven-segment scanner.
// The master drives enable, BCD word and decimal points. The slave (the scanner) drives the display lines.
interface bcd_sseg_scan4_if;
    logic        en;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame;

    modport master (output en, bcd, dp_in, input an_n, seg_n, dp_n, frame);
    modport slave  (input en, bcd, dp_in, output an_n, seg_n, dp_n, frame);
endinterface

// File: rtl/bcd_sseg_scan4.sv
// 4-digit common-anode 7-segment scanner with a once-per-frame BCD snapshot.
// Optional leading-zero blanking is enabled with `define BCD_SSEG_LZ_BLANK_EN.
module bcd_sseg_scan4 #(
    parameter int SCAN_DIV = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    bcd_sseg_scan4_if.slave   bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_bcd_q, shadow_bcd_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic          frame_q, frame_d;
    logic          tick, boundary;

    assign tick     = bus.en && (cnt_q == CNT_MAX);
    assign boundary = tick && (idx_q == 2'd3);

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        frame_d      = 1'b0;
        if (bus.en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) idx_d = idx_q + 2'd1;
            if (boundary) begin
                shadow_bcd_d = bus.bcd;
                shadow_dp_d  = bus.dp_in;
                frame_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_bcd_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            frame_q      <= frame_d;
        end
    end

    // Segment order {g,f,e,d,c,b,a}, active-low. Non-BCD nibbles show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    logic [3:0] digit;
    logic       blank;
    assign digit = shadow_bcd_q[4*idx_q +: 4];

`ifdef BCD_SSEG_LZ_BLANK_EN
    // A digit is blank only while it and every more-significant digit are zero. Digit 0 is never blanked.
    logic [3:0] lz;
    assign lz[3] = (shadow_bcd_q[15:12] == 4'd0);
    assign lz[2] = lz[3] && (shadow_bcd_q[11:8] == 4'd0);
    assign lz[1] = lz[2] && (shadow_bcd_q[7:4] == 4'd0);
    assign lz[0] = 1'b0;
    assign blank = lz[idx_q];
`else
    assign blank = 1'b0;
`endif

    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    always_comb begin
        an_n  = 4'b1111;
        seg_n = 7'b1111111;
        dp_n  = 1'b1;
        if (bus.en) begin
            an_n  = ~(4'b0001 << idx_q);
            seg_n = blank ? 7'b1111111 : seg_decode(digit);
            dp_n  = ~shadow_dp_q[idx_q];
        end
    end

    assign bus.an_n  = an_n;
    assign bus.seg_n = seg_n;
    assign bus.dp_n  = dp_n;
    assign bus.frame = frame_q && bus.en;
endmodule

// File: tb/tb_bcd_sseg_scan4.sv
// Directed bench for bcd_sseg_scan4 (SCAN_DIV=4): vector table plus scan/enable/reset sequences.
module tb_bcd_sseg_scan4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    bcd_sseg_scan4_if u_if ();
    bcd_sseg_scan4 #(.SCAN_DIV(4)) dut (.clk_i(clk), .reset_ni(reset_n), .bus(u_if.slave));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic [3:0][6:0] seg;   // expected seg_n for digit 0..3
        logic [3:0]      dpn;   // expected dp_n for digit 0..3
    } vec_t;

    vec_t vecs[5];
    vec_t v5678;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frame();
        int seen;
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            step(1);
            if (u_if.frame === 1'b1) seen = 1;
        end
        chk("frame_seen", 16'(seen), 16'd1);
    endtask

    // Called on the frame-edge cycle; returns on the next frame edge.
    task automatic check_digits(input vec_t v, input string tag);
        logic [3:0] ea;
        chk({tag, "_frame"}, 16'(u_if.frame), 16'd1);
        for (int i = 0; i < 4; i++) begin
            ea = ~(4'b0001 << i);
            chk($sformatf("%s_an%0d", tag, i), 16'(u_if.an_n), 16'(ea));
            chk($sformatf("%s_seg%0d", tag, i), 16'(u_if.seg_n), 16'(v.seg[i]));
            chk($sformatf("%s_dp%0d", tag, i), 16'(u_if.dp_n), 16'(v.dpn[i]));
            step(4);
        end
    endtask

    initial begin
        logic [3:0] ea;
        logic [6:0] old_seg[4];

        vecs[0] = '{bcd: 16'h1234, dp: 4'b0000,
                    seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, dpn: 4'b1111};
        vecs[1] = '{bcd: 16'h0A09, dp: 4'b0100,
                    seg: {7'b1000000, 7'b0111111, 7'b1000000, 7'b0010000}, dpn: 4'b1011};
        vecs[2] = '{bcd: 16'hFED0, dp: 4'b1010,
                    seg: {7'b0111111, 7'b0111111, 7'b0111111, 7'b1000000}, dpn: 4'b0101};
`ifdef BCD_SSEG_LZ_BLANK_EN
        vecs[3] = '{bcd: 16'h0070, dp: 4'b1000,
                    seg: {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, dpn: 4'b0111};
        vecs[4] = '{bcd: 16'h0000, dp: 4'b0000,
                    seg: {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, dpn: 4'b1111};
`else
        vecs[3] = '{bcd: 16'h0070, dp: 4'b1000,
                    seg: {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}, dpn: 4'b0111};
        vecs[4] = '{bcd: 16'h0000, dp: 4'b0000,
                    seg: {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, dpn: 4'b1111};
`endif
        v5678 = '{bcd: 16'h5678, dp: 4'b0000,
                  seg: {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, dpn: 4'b1111};

        u_if.en = 1'b1;
        u_if.bcd = 16'h1234;
        u_if.dp_in = 4'b0000;

        // Reset state
        #12;
        chk("rst_an", 16'(u_if.an_n), 16'h000E);
        chk("rst_seg", 16'(u_if.seg_n), 16'h0040);
        chk("rst_dp", 16'(u_if.dp_n), 16'd1);
        chk("rst_frame", 16'(u_if.frame), 16'd0);

        // First frame shows 0000; frame pulses exactly 16 clocks after release
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            ea = ~(4'b0001 << ((i / 4) % 4));
            chk($sformatf("f0_frame%0d", i), 16'(u_if.frame), 16'(i == 16));
            chk($sformatf("f0_an%0d", i), 16'(u_if.an_n), 16'(ea));
            if (i < 16) chk($sformatf("f0_seg%0d", i), 16'(u_if.seg_n), 16'h0040);
        end
        check_digits(vecs[0], "v0_first");

        // Vector table: inputs set on a frame edge take effect on the following one
        for (int k = 0; k < 5; k++) begin
            u_if.bcd = vecs[k].bcd;
            u_if.dp_in = vecs[k].dp;
            wait_frame();
            check_digits(vecs[k], $sformatf("v%0d", k));
        end

        // Mid-frame bcd change must not tear the display
        u_if.bcd = 16'h1234;
        u_if.dp_in = 4'b0000;
        wait_frame();
        step(4);
        u_if.bcd = 16'h5678;
        old_seg[1] = 7'b0110000;
        old_seg[2] = 7'b0100100;
        old_seg[3] = 7'b1111001;
        for (int i = 1; i < 4; i++) begin
            ea = ~(4'b0001 << i);
            chk($sformatf("mid_an%0d", i), 16'(u_if.an_n), 16'(ea));
            chk($sformatf("mid_seg%0d", i), 16'(u_if.seg_n), 16'(old_seg[i]));
            step(4);
        end
        check_digits(v5678, "mid_new");

        // Enable low at idx=2,cnt=1 for 10 clocks
        step(9);
        u_if.en = 1'b0;
        #1;
        chk("dis_an0", 16'(u_if.an_n), 16'h000F);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk($sformatf("dis_an%0d", i), 16'(u_if.an_n), 16'h000F);
            chk($sformatf("dis_seg%0d", i), 16'(u_if.seg_n), 16'h007F);
            chk($sformatf("dis_dp%0d", i), 16'(u_if.dp_n), 16'd1);
            chk($sformatf("dis_frame%0d", i), 16'(u_if.frame), 16'd0);
        end
        u_if.en = 1'b1;
        #1;
        chk("res_an_0", 16'(u_if.an_n), 16'h000B);
        chk("res_seg_0", 16'(u_if.seg_n), 16'h0002);
        step(1);
        chk("res_an_1", 16'(u_if.an_n), 16'h000B);
        step(1);
        chk("res_an_2", 16'(u_if.an_n), 16'h000B);
        step(1);
        chk("res_an_3", 16'(u_if.an_n), 16'h0007);

        // Reset at idx=3,cnt=2: immediate reset state, shadow cleared
        step(2);
        reset_n = 1'b0;
        #1;
        chk("mrst_an", 16'(u_if.an_n), 16'h000E);
        chk("mrst_seg", 16'(u_if.seg_n), 16'h0040);
        chk("mrst_frame", 16'(u_if.frame), 16'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(4);
        chk("mrst_an1", 16'(u_if.an_n), 16'h000D);
        chk("mrst_seg1", 16'(u_if.seg_n), 16'h0040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
